memcache_key_extract: RTL and testbench

- Upstream parser for the Jenkins hash stage.
- Consumes a memcached binary-protocol request as a byte stream (one byte per cycle, no backpressure) and decodes the 24-byte request header.
- Skips the extras field, then emits the key bytes one per cycle along with the length and 12-byte-block bookkeeping the hash stage needs (enable, word, key_length, wcount).
- Checks frame consistency and flags malformed requests so the hash result for that frame is discarded.

---
 rtl/memcache_key_extract_pkg.sv | 44 ++++
 rtl/memcache_key_extract_wcount_gen.sv | 35 +++
 rtl/memcache_key_extract.sv | 233 +++++++++++++++++++++++
 tb/tb_memcache_key_extract.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memcache_key_extract_pkg.sv
// Shared types and constants for the memcached request key extractor.
package memcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        EXTRAS,
        KEY,
        BODY,
        DROP
    } state_t;

    // Byte offsets inside the 24-byte binary-protocol request header.
    localparam logic [4:0] OFF_MAGIC   = 5'd0;
    localparam logic [4:0] OFF_OPCODE  = 5'd1;
    localparam logic [4:0] OFF_KEYLEN  = 5'd2;
    localparam logic [4:0] OFF_EXTLEN  = 5'd4;
    localparam logic [4:0] OFF_BODYLEN = 5'd8;
    localparam logic [4:0] HDR_LEN     = 5'd24;

    localparam logic [7:0] MAGIC_REQ = 8'h80;
    localparam logic [7:0] MAXKEY    = 8'd250;
    localparam logic [7:0] BLOCK     = 8'd12;

    // Number of key bytes that fall into the next hash block: min(BLOCK, n).
    function automatic logic [3:0] block_take(input logic [7:0] n);
        return (n >= BLOCK) ? BLOCK[3:0] : n[3:0];
    endfunction

    // First non-empty section after the current one, or IDLE when the frame is complete.
    function automatic state_t next_section(input logic [7:0]  ext,
                                            input logic [7:0]  klen,
                                            input logic [31:0] body);
        if (ext != 8'd0)
            return EXTRAS;
        else if (klen != 8'd0)
            return KEY;
        else if (body != 32'd0)
            return BODY;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/memcache_key_extract_wcount_gen.sv
// Generates the per-byte "bytes left in this 12-byte block" count for the hash stage.
// A mod-12 down-counter walks each block while a remaining-bytes counter sizes the
// next block, so no division is needed.
module memcache_wcount_gen
    import memcache_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       advance,
    input  logic       key_first,
    input  logic [7:0] keylen,
    output logic [3:0] wcount
);

    logic [7:0] rem;

    // Load a fresh block on the first key byte or when the current block runs out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wcount <= 4'd0;
            rem    <= 8'd0;
        end else if (advance) begin
            if (key_first) begin
                wcount <= block_take(keylen);
                rem    <= keylen - {4'd0, block_take(keylen)};
            end else if (wcount == 4'd1) begin
                wcount <= block_take(rem);
                rem    <= rem - {4'd0, block_take(rem)};
            end else begin
                wcount <= wcount - 4'd1;
            end
        end
    end

endmodule

// File: rtl/memcache_key_extract.sv
// Memcached binary-protocol request parser: decodes the header, skips extras,
// streams the key to the hash stage and flags malformed frames.
module memcache_key_extract #(
    parameter logic [7:0] MAXKEY = memcache_pkg::MAXKEY,
    parameter logic [7:0] MAGIC  = memcache_pkg::MAGIC_REQ
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    input  logic       in_eof,
    output logic       key_en,
    output logic [7:0] key_byte,
    output logic [7:0] key_len,
    output logic       key_first,
    output logic       key_last,
    output logic [3:0] wcount,
    output logic [7:0] opcode,
    output logic       hdr_done,
    output logic       frame_ok,
    output logic       frame_err
);
    import memcache_pkg::*;

    state_t      state, state_n;
    logic [4:0]  h, h_n;
    logic        hdr_bad, hdr_bad_n;
    logic [7:0]  klen, klen_n;
    logic [7:0]  ext, ext_n;
    logic [31:0] total, total_n;
    logic [31:0] body, body_n;
    logic [31:0] cnt, cnt_n;

    logic        key_en_n, key_first_n, key_last_n;
    logic        hdr_done_n, frame_ok_n, frame_err_n;
    logic [7:0]  key_byte_n, key_len_n, opcode_n;

    logic        adv;
    logic        in_frame;
    state_t      follow;
    logic [31:0] need_len;
    logic [31:0] body_calc;
    logic        bad_now;
    logic        key_start;

    // Extras plus key must fit inside the declared body; the rest is value bytes.
    assign need_len  = {24'd0, ext} + {24'd0, klen};
    assign body_calc = total - need_len;
    assign bad_now   = hdr_bad || (total < need_len);
    assign key_start = (cnt == {24'd0, klen});

    // Next-state, counter and output decode for one accepted byte.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned and infers a latch.
        state_n     = state;
        h_n         = h;
        hdr_bad_n   = hdr_bad;
        klen_n      = klen;
        ext_n       = ext;
        total_n     = total;
        body_n      = body;
        cnt_n       = cnt;
        key_en_n    = 1'b0;
        key_byte_n  = key_byte;
        key_len_n   = key_len;
        key_first_n = key_first;
        key_last_n  = key_last;
        opcode_n    = opcode;
        hdr_done_n  = 1'b0;
        frame_ok_n  = 1'b0;
        frame_err_n = 1'b0;
        adv         = 1'b0;
        in_frame    = 1'b0;
        follow      = IDLE;

        if (in_valid) begin
            key_first_n = 1'b0;
            key_last_n  = 1'b0;
            if (in_sof) begin
                // A start byte aborts any live frame; DROP already reported its error.
                frame_err_n = in_eof || (state != IDLE && state != DROP);
                if (in_eof) begin
                    state_n = IDLE;
                end else begin
                    state_n   = HDR;
                    h_n       = OFF_MAGIC + 5'd1;
                    hdr_bad_n = (in_data != MAGIC);
                    klen_n    = 8'd0;
                    ext_n     = 8'd0;
                    total_n   = 32'd0;
                end
            end else begin
                case (state)
                    HDR: begin
                        in_frame = 1'b1;
                        h_n      = h + 5'd1;
                        case (h)
                            OFF_OPCODE: opcode_n = in_data;
                            OFF_KEYLEN: begin
                                if (in_data != 8'd0) hdr_bad_n = 1'b1;
                            end
                            OFF_KEYLEN + 5'd1: begin
                                klen_n = in_data;
                                if (in_data > MAXKEY) hdr_bad_n = 1'b1;
                            end
                            OFF_EXTLEN: ext_n = in_data;
                            OFF_BODYLEN, OFF_BODYLEN + 5'd1,
                            OFF_BODYLEN + 5'd2, OFF_BODYLEN + 5'd3:
                                total_n = {total[23:0], in_data};
                            default: ;
                        endcase
                        if (h == HDR_LEN - 5'd1) begin
                            if (bad_now) begin
                                in_frame    = 1'b0;
                                frame_err_n = 1'b1;
                                state_n     = in_eof ? IDLE : DROP;
                            end else begin
                                adv        = 1'b1;
                                hdr_done_n = 1'b1;
                                key_len_n  = klen;
                                body_n     = body_calc;
                                follow     = next_section(ext, klen, body_calc);
                            end
                        end
                    end
                    EXTRAS: begin
                        in_frame = 1'b1;
                        adv      = (cnt == 32'd1);
                        follow   = next_section(8'd0, klen, body);
                    end
                    KEY: begin
                        in_frame    = 1'b1;
                        key_en_n    = 1'b1;
                        key_byte_n  = in_data;
                        key_first_n = key_start;
                        key_last_n  = (cnt == 32'd1);
                        adv         = (cnt == 32'd1);
                        follow      = next_section(8'd0, 8'd0, body);
                    end
                    BODY: begin
                        in_frame = 1'b1;
                        adv      = (cnt == 32'd1);
                        follow   = IDLE;
                    end
                    DROP: begin
                        if (in_eof) state_n = IDLE;
                    end
                    default: ;
                endcase

                // Shared section-boundary handling: truncation, overrun, clean end.
                if (in_frame) begin
                    if (adv) begin
                        if (follow == IDLE) begin
                            frame_ok_n  = in_eof;
                            frame_err_n = !in_eof;
                            state_n     = in_eof ? IDLE : DROP;
                        end else if (in_eof) begin
                            frame_err_n = 1'b1;
                            state_n     = IDLE;
                        end else begin
                            state_n = follow;
                            case (follow)
                                EXTRAS:  cnt_n = {24'd0, ext};
                                KEY:     cnt_n = {24'd0, klen};
                                BODY:    cnt_n = (state == HDR) ? body_calc : body;
                                default: cnt_n = cnt;
                            endcase
                        end
                    end else if (in_eof) begin
                        frame_err_n = 1'b1;
                        state_n     = IDLE;
                    end else if (state != HDR) begin
                        cnt_n = cnt - 32'd1;
                    end
                end
            end
        end
    end

    // State, header fields, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            h         <= 5'd0;
            hdr_bad   <= 1'b0;
            klen      <= 8'd0;
            ext       <= 8'd0;
            total     <= 32'd0;
            body      <= 32'd0;
            cnt       <= 32'd0;
            key_en    <= 1'b0;
            key_byte  <= 8'd0;
            key_len   <= 8'd0;
            key_first <= 1'b0;
            key_last  <= 1'b0;
            opcode    <= 8'd0;
            hdr_done  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: nonblocking assignments so every register samples pre-edge values.
            state     <= state_n;
            h         <= h_n;
            hdr_bad   <= hdr_bad_n;
            klen      <= klen_n;
            ext       <= ext_n;
            total     <= total_n;
            body      <= body_n;
            cnt       <= cnt_n;
            key_en    <= key_en_n;
            key_byte  <= key_byte_n;
            key_len   <= key_len_n;
            key_first <= key_first_n;
            key_last  <= key_last_n;
            opcode    <= opcode_n;
            hdr_done  <= hdr_done_n;
            frame_ok  <= frame_ok_n;
            frame_err <= frame_err_n;
        end
    end

    memcache_wcount_gen u_wcount (
        .CLK       (CLK),
        .RST       (RST),
        .advance   (in_valid && !in_sof && (state == KEY)),
        .key_first (key_start),
        .keylen    (klen),
        .wcount    (wcount)
    );

endmodule

// File: tb/tb_memcache_key_extract.sv
// Directed self-checking bench for memcache_key_extract.
module tb_memcache_key_extract;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_sof = 1'b0;
    logic       in_eof = 1'b0;
    logic       key_en, key_first, key_last, hdr_done, frame_ok, frame_err;
    logic [7:0] key_byte, key_len, opcode;
    logic [3:0] wcount;

    int vectors = 0;
    int miscompares = 0;

    // Per-frame observation log, filled by step().
    logic [7:0] frm[$];
    logic [7:0] kbytes[$];
    int         wcs[$];
    int n_key, kfirst_at, klast_at, hdr_cnt, hdr_at, ok_cnt, ok_at, err_cnt, err_at, stray;
    int klen_seen;
    logic [7:0] hdr_op;
    bit ok_with_last;

    memcache_key_extract dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .key_en(key_en), .key_byte(key_byte),
        .key_len(key_len), .key_first(key_first), .key_last(key_last),
        .wcount(wcount), .opcode(opcode), .hdr_done(hdr_done),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    task automatic clear_log();
        kbytes.delete(); wcs.delete();
        n_key = 0; kfirst_at = -1; klast_at = -1; hdr_cnt = 0; hdr_at = -1; ok_cnt = 0;
        ok_at = -1; err_cnt = 0; err_at = -1; stray = 0; klen_seen = -1; hdr_op = 8'hxx;
        ok_with_last = 1'b0;
    endtask

    // Drive one cycle; idx < 0 marks an idle cycle where no pulse may appear.
    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic e, input int idx);
        @(negedge CLK);
        in_valid = v; in_data = d; in_sof = s; in_eof = e;
        @(posedge CLK);
        #1;
        if (idx < 0) begin
            if (key_en || hdr_done || frame_ok || frame_err) stray++;
        end else begin
            if (key_en) begin
                kbytes.push_back(key_byte);
                wcs.push_back(int'(wcount));
                if (key_first) kfirst_at = n_key;
                if (key_last) begin
                    klast_at  = n_key;
                    klen_seen = int'(key_len);
                    if (frame_ok) ok_with_last = 1'b1;
                end
                n_key++;
            end
            if (hdr_done) begin hdr_cnt++; hdr_at = idx; hdr_op = opcode; end
            if (frame_ok) begin ok_cnt++; ok_at = idx; end
            if (frame_err) begin err_cnt++; err_at = idx; end
        end
    endtask

    task automatic build_hdr(input logic [7:0] magic, input logic [7:0] opc, input logic [15:0] kl,
                             input logic [7:0] e, input logic [31:0] t);
        logic [7:0] b;
        frm.delete();
        for (int i = 0; i < 24; i++) begin
            case (i)
                0: b = magic;
                1: b = opc;
                2: b = kl[15:8];
                3: b = kl[7:0];
                4: b = e;
                8: b = t[31:24];
                9: b = t[23:16];
                10: b = t[15:8];
                11: b = t[7:0];
                default: b = 8'(i) ^ 8'h5A;
            endcase
            frm.push_back(b);
        end
    endtask

    task automatic build_get(input logic [7:0] magic);
        build_hdr(magic, 8'h00, 16'd5, 8'd0, 32'd5);
        frm.push_back(8'h68); frm.push_back(8'h65); frm.push_back(8'h6C);
        frm.push_back(8'h6C); frm.push_back(8'h6F);
    endtask

    task automatic send_frame(input int gap, input bit do_eof);
        clear_log();
        for (int i = 0; i < frm.size(); i++) begin
            step(1'b1, frm[i], i == 0, do_eof && (i == frm.size() - 1), i);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, 1'b0, 1'b0, -1);
        end
    endtask

    // Expectations shared by every clean GET "hello" frame.
    task automatic expect_get(input string tag);
        logic [7:0] exp_k[5];
        exp_k = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        vectors++; if (n_key !== 5) begin miscompares++; $display("FAIL %s_nkey: got %0d need 5", tag, n_key); end
        for (int j = 0; j < 5 && j < n_key; j++) begin
            vectors++;
            if (kbytes[j] !== exp_k[j] || wcs[j] !== 5 - j) begin
                miscompares++;
                $display("FAIL %s_key%0d: byte %h wcount %0d, need byte %h wcount %0d", tag, j, kbytes[j], wcs[j], exp_k[j], 5 - j);
            end
        end
        vectors++; if (hdr_cnt !== 1 || hdr_at !== 23 || hdr_op !== 8'h00) begin miscompares++; $display("FAIL %s_hdr: cnt %0d at %0d op %h, need 1 at 23 op 00", tag, hdr_cnt, hdr_at, hdr_op); end
        vectors++; if (kfirst_at !== 0 || klast_at !== 4 || klen_seen !== 5) begin miscompares++; $display("FAIL %s_firstlast: first %0d last %0d key_len %0d, need 0 4 5", tag, kfirst_at, klast_at, klen_seen); end
        vectors++; if (ok_cnt !== 1 || ok_at !== 28 || !ok_with_last) begin miscompares++; $display("FAIL %s_ok: cnt %0d at %0d with_last %0d, need 1 at 28 with_last 1", tag, ok_cnt, ok_at, ok_with_last); end
        vectors++; if (err_cnt !== 0) begin miscompares++; $display("FAIL %s_err: got %0d need 0", tag, err_cnt); end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({key_en, key_byte, key_len, key_first, key_last, wcount, opcode, hdr_done, frame_ok, frame_err} !== 36'd0) begin
            miscompares++; $display("FAIL reset_outputs: got nonzero, need all 0");
        end
        @(negedge CLK); RST = 1'b0;
    endtask

    task automatic test_get();
        build_get(8'h80);
        send_frame(0, 1'b1);
        expect_get("get");
    endtask

    task automatic test_set();
        build_hdr(8'h80, 8'h01, 16'd14, 8'd8, 32'd25);
        for (int i = 0; i < 8; i++) frm.push_back(8'hE0 + 8'(i));
        for (int i = 0; i < 14; i++) frm.push_back(8'h61 + 8'(i));
        for (int i = 0; i < 3; i++) frm.push_back(8'hF0 + 8'(i));
        send_frame(0, 1'b1);
        vectors++; if (n_key !== 14) begin miscompares++; $display("FAIL set_nkey: got %0d need 14", n_key); end
        for (int j = 0; j < 14 && j < n_key; j++) begin
            vectors++;
            if (kbytes[j] !== 8'h61 + 8'(j) || wcs[j] !== ((j < 12) ? 12 - j : 14 - j)) begin
                miscompares++;
                $display("FAIL set_key%0d: byte %h wcount %0d, need byte %h wcount %0d", j, kbytes[j], wcs[j], 8'h61 + 8'(j), (j < 12) ? 12 - j : 14 - j);
            end
        end
        vectors++; if (hdr_cnt !== 1 || hdr_op !== 8'h01) begin miscompares++; $display("FAIL set_hdr: cnt %0d op %h, need 1 op 01", hdr_cnt, hdr_op); end
        vectors++; if (klast_at !== 13 || klen_seen !== 14) begin miscompares++; $display("FAIL set_last: last %0d key_len %0d, need 13 14", klast_at, klen_seen); end
        vectors++; if (ok_cnt !== 1 || ok_at !== 48 || err_cnt !== 0) begin miscompares++; $display("FAIL set_ok: ok %0d at %0d err %0d, need 1 at 48 err 0", ok_cnt, ok_at, err_cnt); end
    endtask

    task automatic test_bad_magic();
        build_get(8'h81);
        send_frame(0, 1'b1);
        vectors++; if (err_cnt !== 1 || err_at !== 23) begin miscompares++; $display("FAIL magic_err: cnt %0d at %0d, need 1 at 23", err_cnt, err_at); end
        vectors++; if (n_key !== 0 || hdr_cnt !== 0 || ok_cnt !== 0) begin miscompares++; $display("FAIL magic_quiet: key %0d hdr %0d ok %0d, need 0 0 0", n_key, hdr_cnt, ok_cnt); end
        build_get(8'h80);
        send_frame(0, 1'b1);
        expect_get("after_magic");
    endtask

    task automatic test_bad_lengths();
        build_hdr(8'h80, 8'h00, 16'd251, 8'd0, 32'd251);
        for (int i = 0; i < 4; i++) frm.push_back(8'h41);
        send_frame(0, 1'b1);
        vectors++; if (err_cnt !== 1 || err_at !== 23 || hdr_cnt !== 0 || n_key !== 0) begin miscompares++; $display("FAIL keylen251: err %0d at %0d hdr %0d key %0d, need 1 at 23 0 0", err_cnt, err_at, hdr_cnt, n_key); end
        build_hdr(8'h80, 8'h00, 16'd5, 8'd0, 32'd3);
        for (int i = 0; i < 3; i++) frm.push_back(8'h41);
        send_frame(0, 1'b1);
        vectors++; if (err_cnt !== 1 || err_at !== 23 || hdr_cnt !== 0 || ok_cnt !== 0) begin miscompares++; $display("FAIL body_short: err %0d at %0d hdr %0d ok %0d, need 1 at 23 0 0", err_cnt, err_at, hdr_cnt, ok_cnt); end
    endtask

    task automatic test_framing();
        // Truncated on key byte 3 of 5.
        build_get(8'h80);
        void'(frm.pop_back()); void'(frm.pop_back());
        send_frame(0, 1'b1);
        vectors++; if (err_cnt !== 1 || err_at !== 26 || n_key !== 3 || ok_cnt !== 0) begin miscompares++; $display("FAIL truncate: err %0d at %0d key %0d ok %0d, need 1 at 26 3 0", err_cnt, err_at, n_key, ok_cnt); end
        // Overrun: one byte past the declared body.
        build_get(8'h80);
        frm.push_back(8'hAA);
        send_frame(0, 1'b1);
        vectors++; if (err_cnt !== 1 || err_at !== 28 || ok_cnt !== 0 || n_key !== 5) begin miscompares++; $display("FAIL overrun: err %0d at %0d ok %0d key %0d, need 1 at 28 0 5", err_cnt, err_at, ok_cnt, n_key); end
        // Zero-body frame ends on header byte 23.
        build_hdr(8'h80, 8'h0A, 16'd0, 8'd0, 32'd0);
        send_frame(0, 1'b1);
        vectors++; if (hdr_cnt !== 1 || ok_cnt !== 1 || ok_at !== 23 || n_key !== 0 || err_cnt !== 0) begin miscompares++; $display("FAIL zero_body: hdr %0d ok %0d at %0d key %0d err %0d, need 1 1 at 23 0 0", hdr_cnt, ok_cnt, ok_at, n_key, err_cnt); end
        // sof and eof on the same byte.
        clear_log();
        step(1'b1, 8'h80, 1'b1, 1'b1, 0);
        vectors++; if (err_cnt !== 1 || hdr_cnt !== 0) begin miscompares++; $display("FAIL sof_eof: err %0d hdr %0d, need 1 0", err_cnt, hdr_cnt); end
    endtask

    task automatic test_back_to_back();
        // SET cut in the body by the sof of a new GET.
        build_hdr(8'h80, 8'h01, 16'd14, 8'd8, 32'd25);
        for (int i = 0; i < 23; i++) frm.push_back(8'h30 + 8'(i));
        send_frame(0, 1'b0);
        vectors++; if (err_cnt !== 0 || n_key !== 14) begin miscompares++; $display("FAIL partial_set: err %0d key %0d, need 0 14", err_cnt, n_key); end
        build_get(8'h80);
        send_frame(0, 1'b1);
        vectors++; if (err_cnt !== 1 || err_at !== 0) begin miscompares++; $display("FAIL sof_abort: err %0d at %0d, need 1 at 0", err_cnt, err_at); end
        vectors++; if (n_key !== 5 || ok_cnt !== 1 || ok_at !== 28) begin miscompares++; $display("FAIL sof_restart: key %0d ok %0d at %0d, need 5 1 at 28", n_key, ok_cnt, ok_at); end
    endtask

    task automatic test_valid_gaps();
        build_get(8'h80);
        send_frame(1, 1'b1);
        expect_get("gaps");
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL gaps_stray: got %0d pulses on idle cycles, need 0", stray); end
    endtask

    task automatic test_reset_midframe();
        build_get(8'h80);
        clear_log();
        for (int i = 0; i < 26; i++) step(1'b1, frm[i], i == 0, 1'b0, i);
        vectors++; if (n_key !== 2 || err_cnt !== 0) begin miscompares++; $display("FAIL pre_rst: key %0d err %0d, need 2 0", n_key, err_cnt); end
        @(negedge CLK);
        RST = 1'b1; in_valid = 1'b0;
        @(posedge CLK);
        #1;
        vectors++;
        if ({key_en, key_byte, key_len, key_first, key_last, wcount, opcode, hdr_done, frame_ok, frame_err} !== 36'd0) begin
            miscompares++; $display("FAIL rst_outputs: got nonzero, need all 0");
        end
        @(negedge CLK); RST = 1'b0;
        clear_log();
        for (int i = 26; i < 29; i++) step(1'b1, frm[i], 1'b0, i == 28, i);
        vectors++; if (n_key !== 0 || err_cnt !== 0 || ok_cnt !== 0) begin miscompares++; $display("FAIL rst_silent: key %0d err %0d ok %0d, need 0 0 0", n_key, err_cnt, ok_cnt); end
        send_frame(0, 1'b1);
        expect_get("after_rst");
    endtask

    initial begin
        clear_log();
        test_reset();
        test_get();
        test_set();
        test_bad_magic();
        test_bad_lengths();
        test_framing();
        test_back_to_back();
        test_valid_gaps();
        test_reset_midframe();
        step(1'b0, 8'h00, 1'b0, 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
